hazard_ctrl: RTL and testbench

- Hazard controller for the 5-stage pipeline.
- Drives execute-stage forwarding selects (ALU operand A/B muxes: 00 register file, 01 W-stage result, 10 M-stage ALU output) and decode-stage branch-compare forwarding.
- Generates fetch/decode stalls and execute flush for load-use, branch-operand and multi-cycle mult/div hazards.
- Owns the sequencing FSM of the multi-cycle mult/div unit.

---
 rtl/hazard_ctrl_if.sv | 47 ++++
 rtl/hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: decode/execute/memory/writeback register
// identifiers in, forwarding selects, stalls and mult/div status out.
interface hazard_ctrl_if;
  logic [4:0] rs_D;
  logic [4:0] rt_D;
  logic       branch_D;
  logic       md_use_D;
  logic [4:0] rs_E;
  logic [4:0] rt_E;
  logic [4:0] reg_id_E;
  logic       reg_write_E;
  logic       mem_to_reg_E;
  logic       md_start_E;
  logic       md_div_E;
  logic [4:0] reg_id_M;
  logic       reg_write_M;
  logic       mem_to_reg_M;
  logic [4:0] reg_id_W;
  logic       reg_write_W;
  logic [1:0] forwardA_E;
  logic [1:0] forwardB_E;
  logic       forwardA_D;
  logic       forwardB_D;
  logic       stall_F;
  logic       stall_D;
  logic       flush_E;
  logic       md_busy;
  logic       md_done;

  modport master (
    output rs_D, rt_D, branch_D, md_use_D,
    output rs_E, rt_E, reg_id_E, reg_write_E, mem_to_reg_E, md_start_E, md_div_E,
    output reg_id_M, reg_write_M, mem_to_reg_M,
    output reg_id_W, reg_write_W,
    input  forwardA_E, forwardB_E, forwardA_D, forwardB_D,
    input  stall_F, stall_D, flush_E, md_busy, md_done
  );

  modport slave (
    input  rs_D, rt_D, branch_D, md_use_D,
    input  rs_E, rt_E, reg_id_E, reg_write_E, mem_to_reg_E, md_start_E, md_div_E,
    input  reg_id_M, reg_write_M, mem_to_reg_M,
    input  reg_id_W, reg_write_W,
    output forwardA_E, forwardB_E, forwardA_D, forwardB_D,
    output stall_F, stall_D, flush_E, md_busy, md_done
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: operand forwarding, stall/flush
// generation and the mult/div sequencer. Optional stall counters: HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int MULT_LAT = 4,
  parameter int DIV_LAT  = 32
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   md_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(DIV_LAT + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  // Register 0 is hard-wired, so a write to it can never create a dependency.
  function automatic logic src_match(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       we_m,
    input logic [4:0] id_m,
    input logic       we_w,
    input logic [4:0] id_w
  );
    logic [1:0] sel;
    if (we_m && src_match(id_m, src)) begin
      sel = 2'b10;
    end else if (we_w && src_match(id_w, src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  md_state_t        state_r;
  md_state_t        state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  logic [1:0] fwd_a_e_s;
  logic [1:0] fwd_b_e_s;
  logic       fwd_a_d_s;
  logic       fwd_b_d_s;
  logic       lw_stall_s;
  logic       br_stall_s;
  logic       md_stall_s;
  logic       stall_s;
  logic       md_busy_s;
  logic       md_done_s;
  logic       d_hit_e_s;
  logic       d_hit_m_s;

  // Execute-stage ALU operand and decode-stage branch operand forwarding.
  always_comb begin
    fwd_a_e_s = fwd_sel(hz.rs_E, hz.reg_write_M, hz.reg_id_M, hz.reg_write_W, hz.reg_id_W);
    fwd_b_e_s = fwd_sel(hz.rt_E, hz.reg_write_M, hz.reg_id_M, hz.reg_write_W, hz.reg_id_W);
    fwd_a_d_s = hz.reg_write_M & src_match(hz.reg_id_M, hz.rs_D);
    fwd_b_d_s = hz.reg_write_M & src_match(hz.reg_id_M, hz.rt_D);
  end

  assign md_busy_s = (state_r == BUSY);
  assign md_done_s = (state_r == BUSY) && (cnt_r == CNT_ZERO);

  // Stall sources; while reset is high the sequencer is treated as idle.
  always_comb begin
    d_hit_e_s  = src_match(hz.reg_id_E, hz.rs_D) | src_match(hz.reg_id_E, hz.rt_D);
    d_hit_m_s  = src_match(hz.reg_id_M, hz.rs_D) | src_match(hz.reg_id_M, hz.rt_D);
    lw_stall_s = hz.mem_to_reg_E & d_hit_e_s;
    br_stall_s = hz.branch_D & ((hz.reg_write_E & d_hit_e_s) | (hz.mem_to_reg_M & d_hit_m_s));
    md_stall_s = hz.md_use_D & ((md_busy_s & ~reset) | hz.md_start_E);
    stall_s    = lw_stall_s | br_stall_s | md_stall_s;
  end

  // Mult/div sequencer next-state and countdown.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (hz.md_start_E) begin
          state_nxt_s = BUSY;
          cnt_nxt_s   = hz.md_div_E ? DIV_LOAD : MULT_LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] md_stall_cnt_r;

  // Free-running stall counters, wrapping naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r    <= 32'd0;
      md_stall_cnt_r <= 32'd0;
    end else begin
      if (stall_s) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
      if (md_stall_s) begin
        md_stall_cnt_r <= md_stall_cnt_r + 32'd1;
      end
    end
  end

  assign stall_cnt    = stall_cnt_r;
  assign md_stall_cnt = md_stall_cnt_r;
`endif

  assign hz.forwardA_E = fwd_a_e_s;
  assign hz.forwardB_E = fwd_b_e_s;
  assign hz.forwardA_D = fwd_a_d_s;
  assign hz.forwardB_D = fwd_b_d_s;
  assign hz.stall_F    = stall_s;
  assign hz.stall_D    = stall_s;
  assign hz.flush_E    = stall_s;
  assign hz.md_busy    = md_busy_s;
  assign hz.md_done    = md_done_s;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational vector table plus mult/div sequences.
module tb_hazard_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  hazard_ctrl_if hz ();

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] md_stall_cnt;
`endif

  hazard_ctrl #(
    .MULT_LAT (4),
    .DIV_LAT  (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .md_stall_cnt (md_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic       br_d;
    logic       mdu_d;
    logic [4:0] rs_e;
    logic [4:0] rt_e;
    logic [4:0] id_e;
    logic       we_e;
    logic       ld_e;
    logic [4:0] id_m;
    logic       we_m;
    logic       ld_m;
    logic [4:0] id_w;
    logic       we_w;
    logic [1:0] x_fa_e;
    logic [1:0] x_fb_e;
    logic       x_fa_d;
    logic       x_fb_d;
    logic       x_stall;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    hz.rs_D = 5'd0; hz.rt_D = 5'd0; hz.branch_D = 1'b0; hz.md_use_D = 1'b0;
    hz.rs_E = 5'd0; hz.rt_E = 5'd0; hz.reg_id_E = 5'd0; hz.reg_write_E = 1'b0;
    hz.mem_to_reg_E = 1'b0; hz.md_start_E = 1'b0; hz.md_div_E = 1'b0;
    hz.reg_id_M = 5'd0; hz.reg_write_M = 1'b0; hz.mem_to_reg_M = 1'b0;
    hz.reg_id_W = 5'd0; hz.reg_write_W = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    hz.rs_D = v.rs_d; hz.rt_D = v.rt_d; hz.branch_D = v.br_d; hz.md_use_D = v.mdu_d;
    hz.rs_E = v.rs_e; hz.rt_E = v.rt_e; hz.reg_id_E = v.id_e; hz.reg_write_E = v.we_e;
    hz.mem_to_reg_E = v.ld_e; hz.reg_id_M = v.id_m; hz.reg_write_M = v.we_m;
    hz.mem_to_reg_M = v.ld_m; hz.reg_id_W = v.id_w; hz.reg_write_W = v.we_w;
  endtask

  task automatic check_stall(input string name, input logic exp);
    check({name, ".stall_F"}, {31'd0, hz.stall_F}, {31'd0, exp});
    check({name, ".stall_D"}, {31'd0, hz.stall_D}, {31'd0, exp});
    check({name, ".flush_E"}, {31'd0, hz.flush_E}, {31'd0, exp});
  endtask

  task automatic check_md(input string name, input logic busy, input logic done);
    check({name, ".md_busy"}, {31'd0, hz.md_busy}, {31'd0, busy});
    check({name, ".md_done"}, {31'd0, hz.md_done}, {31'd0, done});
  endtask

  initial begin
    int done_pulses;
    n_checks = 0;
    n_fail   = 0;

    //            rs_d   rt_d   br    mdu   rs_e   rt_e   id_e   we_e  ld_e  id_m   we_m  ld_m  id_w   we_w  faE    fbE    faD   fbD   stall
    vecs[0]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd5,  5'd0,  5'd0,  1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 5'd5,  1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd5,  5'd0,  5'd0,  1'b0, 1'b0, 5'd5,  1'b0, 1'b0, 5'd5,  1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 5'd5,  1'b0, 1'b0, 5'd5,  1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd7,  5'd7,  5'd0,  1'b0, 1'b0, 5'd7,  1'b1, 1'b0, 5'd7,  1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd2,  5'd6,  5'd0,  1'b0, 1'b0, 5'd6,  1'b0, 1'b0, 5'd6,  1'b1, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{5'd1,  5'd8,  1'b0, 1'b0, 5'd0,  5'd0,  5'd8,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{5'd1,  5'd8,  1'b0, 1'b0, 5'd0,  5'd0,  5'd9,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{5'd8,  5'd2,  1'b0, 1'b0, 5'd0,  5'd0,  5'd8,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{5'd3,  5'd0,  1'b1, 1'b0, 5'd0,  5'd0,  5'd3,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{5'd3,  5'd0,  1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 5'd3,  1'b1, 1'b0, 5'd0,  1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{5'd0,  5'd4,  1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 5'd4,  1'b1, 1'b1, 5'd0,  1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{5'd3,  5'd0,  1'b0, 1'b0, 5'd0,  5'd0,  5'd3,  1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{5'd0,  5'd12, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 5'd12, 1'b1, 1'b0, 5'd0,  1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  1'b1, 1'b1, 5'd0,  1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{5'd4,  5'd5,  1'b0, 1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

    // Reset state; combinational outputs stay live during reset.
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    check_md("reset", 1'b0, 1'b0);
    check_stall("reset_idle", 1'b0);
    hz.md_use_D = 1'b1; hz.md_start_E = 1'b1;
    #1;
    check_stall("reset_md_start", 1'b1);
    hz.md_start_E = 1'b0; hz.rs_E = 5'd9; hz.reg_write_M = 1'b1; hz.reg_id_M = 5'd9;
    #1;
    check_stall("reset_md_use_only", 1'b0);
    check("reset_fwdA_E", {30'd0, hz.forwardA_E}, {30'd0, 2'b10});
    clear_inputs();
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      apply(vecs[i]);
      #1;
      check($sformatf("vec%0d.forwardA_E", i), {30'd0, hz.forwardA_E}, {30'd0, vecs[i].x_fa_e});
      check($sformatf("vec%0d.forwardB_E", i), {30'd0, hz.forwardB_E}, {30'd0, vecs[i].x_fb_e});
      check($sformatf("vec%0d.forwardA_D", i), {31'd0, hz.forwardA_D}, {31'd0, vecs[i].x_fa_d});
      check($sformatf("vec%0d.forwardB_D", i), {31'd0, hz.forwardB_D}, {31'd0, vecs[i].x_fb_d});
      check_stall($sformatf("vec%0d", i), vecs[i].x_stall);
      tick();
    end
    clear_inputs();
    tick();

    // Multiply: busy for 4 cycles, done in the last, md_use_D stalls throughout.
    hz.md_start_E = 1'b1; hz.md_div_E = 1'b0; hz.md_use_D = 1'b1;
    #1;
    check_stall("mul_start", 1'b1);
    check_md("mul_start", 1'b0, 1'b0);
    tick();
    hz.md_start_E = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) tick();
      #1;
      check_md($sformatf("mul_k%0d", k), (k <= 4), (k == 4));
      check_stall($sformatf("mul_k%0d", k), (k <= 4));
    end
    clear_inputs();
    tick();

    // Full divide; a start pulse mid-operation is ignored.
    hz.md_start_E = 1'b1; hz.md_div_E = 1'b1;
    tick();
    hz.md_start_E = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      if (k > 1) tick();
      hz.md_start_E = (k == 5);
      hz.md_div_E   = 1'b0;
      #1;
      check_md($sformatf("div_k%0d", k), (k <= 32), (k == 32));
    end
    clear_inputs();
    tick();

    // Divide abandoned by reset in its tenth busy cycle.
    hz.md_start_E = 1'b1; hz.md_div_E = 1'b1;
    tick();
    hz.md_start_E = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) tick();
      check_md($sformatf("abort_k%0d", k), 1'b1, 1'b0);
    end
    reset = 1'b1; hz.md_use_D = 1'b1;
    #1;
    check_md("abort_reset_cycle", 1'b1, 1'b0);
    check_stall("abort_reset_cycle", 1'b0);
    tick();
    check_md("abort_after_reset", 1'b0, 1'b0);
    reset = 1'b0; hz.md_use_D = 1'b0;
    done_pulses = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (hz.md_done === 1'b1 || hz.md_busy === 1'b1) done_pulses++;
    end
    check("abort_no_done", done_pulses, 32'd0);
    hz.md_start_E = 1'b1; hz.md_div_E = 1'b0;
    tick();
    hz.md_start_E = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) tick();
      check_md($sformatf("post_abort_mul_k%0d", k), (k <= 4), (k == 4));
    end
    clear_inputs();
    tick();

`ifdef HAZARD_PERF_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("perf_reset.stall_cnt", stall_cnt, 32'd0);
    check("perf_reset.md_stall_cnt", md_stall_cnt, 32'd0);
    hz.mem_to_reg_E = 1'b1; hz.reg_write_E = 1'b1; hz.reg_id_E = 5'd8; hz.rt_D = 5'd8;
    tick(); tick(); tick();
    clear_inputs();
    #1;
    check("perf_lw.stall_cnt", stall_cnt, 32'd3);
    check("perf_lw.md_stall_cnt", md_stall_cnt, 32'd0);
    hz.md_start_E = 1'b1; hz.md_div_E = 1'b0;
    tick();
    hz.md_start_E = 1'b0; hz.md_use_D = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    check_md("perf_mul_end", 1'b0, 1'b0);
    hz.md_use_D = 1'b0;
    tick();
    check("perf_total.stall_cnt", stall_cnt, 32'd7);
    check("perf_total.md_stall_cnt", md_stall_cnt, 32'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("perf_clear.stall_cnt", stall_cnt, 32'd0);
    check("perf_clear.md_stall_cnt", md_stall_cnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
